lsa_adc_scanner: RTL
====================

Name: lsa_adc_scanner

Overview:
- Parametrised SPI scanner for an MCP3208-class 8-input, 12-bit ADC feeding the line-sensor array (LSA).
- Converts every enabled channel in ascending order, one CS frame per channel.
- Publishes each result as a streaming strobe and in a per-channel result bank.
- Sits between the ADC pins and the line-following control logic; supports single-shot and continuous scanning.

Parameters:
- NUM_CH, 4, channels scanned, 1..8; indices 0..NUM_CH-1 map to ADC addresses 0..NUM_CH-1.
- DATA_W, 12, conversion result width.
- CLK_DIV, 4, clk cycles per SCLK half-period, >=1.
- GAP_CYCLES, 2, clk cycles cs_n is held high between frames, >=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a scan when idle.
- cont  in  1  1 = restart a scan automatically after scan_done.
- ch_mask  in  NUM_CH  channel enables, latched at scan start.
- diff_mode  in  1  SGL/DIFF bit value sent in each frame (1 = single-ended).
- sclk  out  1  SPI clock, idles low.
- cs_n  out  1  ADC chip select, active low.
- din  out  1  serial data to the ADC.
- dout  in  1  serial data from the ADC.
- busy  out  1  high from scan start until scan_done.
- sample_valid  out  1  one-cycle strobe; a new result is present.
- sample_ch  out  3  channel index of the current result.
- sample_data  out  DATA_W  result, MSB-aligned as received.
- scan_done  out  1  one-cycle pulse after the last enabled channel completes.
- results  out  NUM_CH*DATA_W  result bank; channel k occupies bits [k*DATA_W +: DATA_W].

Behaviour:
- Reset (rst==0 at posedge):
  - Forces cs_n=1, sclk=0, din=0, busy=0, sample_valid=0, scan_done=0, sample_ch=0, sample_data=0, results=0.
  - Puts the FSM in IDLE.
  - Reset mid-frame aborts the frame; no strobe is emitted for the aborted frame.
- IDLE:
  - start==1 with ch_mask!=0: latch the mask, set busy, select the lowest enabled channel, go to SETUP.
  - start==1 with ch_mask==0: ignored.
  - start while busy: ignored.
- SETUP:
  - cs_n=0, sclk=0.
  - din drives the start bit (1).
  - Lasts CLK_DIV cycles, then goes to SHIFT.
- SHIFT: frame of 7+DATA_W SCLK periods.
  - Each period is CLK_DIV cycles low followed by CLK_DIV cycles high.
  - din changes only while sclk is low. Bit sequence: start=1, SGL=diff_mode, D2, D1, D0 (MSB first), then 0 for the remaining periods.
  - dout is sampled at each sclk rising edge. Period 6 (sample window) and period 7 (null bit) are discarded; periods 8..7+DATA_W fill the result MSB first.
- PUBLISH:
  - Starts on the clk cycle after the last SCLK high phase ends.
  - Same cycle: sclk=0, cs_n=1, sample_valid=1, sample_ch/sample_data updated, results slice updated.
  - sample_ch/sample_data hold their values until the next PUBLISH.
- GAP:
  - cs_n held high for GAP_CYCLES.
  - Then SETUP for the next enabled channel; disabled channels are skipped with zero cycles.
  - After the last enabled channel: scan_done pulses in the cycle following GAP and busy drops that same cycle.
- Continuous mode:
  - If cont==1 when scan_done fires, the mask is re-latched and SETUP begins on the next cycle. busy still drops for exactly one cycle.
  - If cont==1 and the re-latched mask is 0, return to IDLE.
- Frame length: CLK_DIV + 2*CLK_DIV*(7+DATA_W) + 1 + GAP_CYCLES clk cycles. With defaults this is 4+152+1+2 = 159.
- start coincident with scan_done: ignored (cont governs the restart).

Optional Feature:
- Macro LSA_ADC_THRESH_EN.
- When defined, adds two ports:
  - thresh  in  DATA_W  detection threshold.
  - line_bits  out  NUM_CH  bit k=1 when channel k's latest result >= thresh (unsigned compare).
- line_bits[k] updates in the PUBLISH cycle of channel k and resets to 0.
- When undefined, neither port exists and there is no compare logic.

Test Plan:
- Defaults; ADC model returns 0xA5C on ch0..3; start pulse, ch_mask=4'b1111:
  - 4 sample_valid strobes with sample_ch 0,1,2,3, each 159 cycles apart.
  - results = {4{12'hA5C}}; scan_done exactly once; busy then 0.
- ch_mask=4'b1010, model returns ch1=0x123, ch3=0xFFF:
  - Only ch1 and ch3 are framed.
  - din frames carry address bits 001 and 011.
  - results slices 0 and 2 stay 0.
- Bit-level check of the ch2 frame, diff_mode=1:
  - din over the first 5 SCLK rising edges = 1,1,0,1,0.
  - cs_n high exactly GAP_CYCLES between frames.
  - sclk period = 8 clk.
- rst driven 0 during period 10 of the ch1 frame:
  - Next cycle cs_n=1, sclk=0, busy=0, results=0.
  - No sample_valid for ch1.
- cont=1, ch_mask=4'b0001:
  - Back-to-back scans, scan_done every frame.
  - Deasserting cont stops after the current scan completes.
- With LSA_ADC_THRESH_EN, thresh=0x800, model ch0..3 = 0x7FF, 0x800, 0x000, 0xFFF:
  - line_bits = 4'b1010 after scan_done.

Source files
------------

// File: rtl/lsa_adc_scanner.sv
// lsa_adc_scanner: SPI scanner for an MCP3208-class 8-input ADC feeding the
// line-sensor array. Each enabled channel is converted in ascending order,
// one chip-select frame per channel. Every result is published as a one-cycle
// strobe and is also stored in a per-channel result bank.
// Optional feature macro: LSA_ADC_THRESH_EN adds a per-channel threshold
// compare (ports thresh / line_bits).
module lsa_adc_scanner #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 12,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cont,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     diff_mode,
  output logic                     sclk,
  output logic                     cs_n,
  output logic                     din,
  input  logic                     dout,
  output logic                     busy,
  output logic                     sample_valid,
  output logic [2:0]               sample_ch,
  output logic [DATA_W-1:0]        sample_data,
  output logic                     scan_done,
`ifdef LSA_ADC_THRESH_EN
  input  logic [DATA_W-1:0]        thresh,
  output logic [NUM_CH-1:0]        line_bits,
`endif
  output logic [NUM_CH*DATA_W-1:0] results
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, PUBLISH, GAP, DONE} state_t;

  // One frame carries 7 header/turnaround periods followed by the data bits.
  localparam int NBITS = 7 + DATA_W;
  localparam int CMAX  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int BIT_W = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [BIT_W-1:0] BIT_DATA = BIT_W'(7);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                phase_reg, phase_next;   // 0 = sclk low half, 1 = high half
  logic [BIT_W-1:0]    bit_reg, bit_next;       // SCLK period index minus one
  logic [2:0]          ch_reg, ch_next;
  logic [NUM_CH-1:0]   pending_reg, pending_next;
  logic                sgl_reg, sgl_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic [2:0]          sample_ch_reg, sample_ch_next;
  logic [DATA_W-1:0]   sample_data_reg, sample_data_next;
  logic [NUM_CH-1:0]   rem;
  logic                load;

  // Index of the lowest set bit; callers guarantee the mask is non-zero.
  function automatic logic [2:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = 3'd0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (m[k]) lowest = 3'(k);
    end
  endfunction

  // Next-state, datapath next values and pin outputs decoded from the state.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    phase_next       = phase_reg;
    bit_next         = bit_reg;
    ch_next          = ch_reg;
    pending_next     = pending_reg;
    sgl_next         = sgl_reg;
    shift_next       = shift_reg;
    sample_ch_next   = sample_ch_reg;
    sample_data_next = sample_data_reg;
    load             = 1'b0;
    sclk             = 1'b0;
    cs_n             = 1'b1;
    din              = 1'b0;
    busy             = 1'b0;
    sample_valid     = 1'b0;
    scan_done        = 1'b0;

    // Channels still to convert once the current one is finished.
    rem = pending_reg;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_reg == 3'(k)) rem[k] = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (start && (|ch_mask)) begin
          pending_next = ch_mask;
          ch_next      = lowest(ch_mask);
          sgl_next     = diff_mode;
          cnt_next     = '0;
          state_next   = SETUP;
        end
      end
      SETUP: begin
        busy = 1'b1;
        cs_n = 1'b0;
        din  = 1'b1;
        if (cnt_reg == DIV_LAST) begin
          cnt_next   = '0;
          phase_next = 1'b0;
          bit_next   = '0;
          shift_next = '0;
          state_next = SHIFT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        cs_n = 1'b0;
        sclk = phase_reg;
        // din only moves when bit_reg advances, i.e. on the sclk falling edge.
        if (bit_reg == BIT_W'(0))      din = 1'b1;
        else if (bit_reg == BIT_W'(1)) din = sgl_reg;
        else if (bit_reg == BIT_W'(2)) din = ch_reg[2];
        else if (bit_reg == BIT_W'(3)) din = ch_reg[1];
        else if (bit_reg == BIT_W'(4)) din = ch_reg[0];
        else                           din = 1'b0;
        if (cnt_reg == DIV_LAST) begin
          cnt_next = '0;
          if (!phase_reg) begin
            // Rising sclk edge: sample window and null bit are dropped.
            phase_next = 1'b1;
            if (bit_reg >= BIT_DATA) shift_next = {shift_reg[DATA_W-2:0], dout};
          end else begin
            phase_next = 1'b0;
            if (bit_reg == BIT_LAST) begin
              load             = 1'b1;
              sample_ch_next   = ch_reg;
              sample_data_next = shift_reg;
              state_next       = PUBLISH;
            end else begin
              bit_next = bit_reg + 1'b1;
            end
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PUBLISH: begin
        busy         = 1'b1;
        sample_valid = 1'b1;
        cnt_next     = '0;
        state_next   = GAP;
      end
      GAP: begin
        busy = 1'b1;
        if (cnt_reg == GAP_LAST) begin
          cnt_next = '0;
          if (|rem) begin
            pending_next = rem;
            ch_next      = lowest(rem);
            state_next   = SETUP;
          end else begin
            state_next = DONE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        scan_done = 1'b1;
        if (cont && (|ch_mask)) begin
          pending_next = ch_mask;
          ch_next      = lowest(ch_mask);
          sgl_next     = diff_mode;
          cnt_next     = '0;
          state_next   = SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      phase_reg       <= 1'b0;
      bit_reg         <= '0;
      ch_reg          <= 3'd0;
      pending_reg     <= '0;
      sgl_reg         <= 1'b0;
      shift_reg       <= '0;
      sample_ch_reg   <= 3'd0;
      sample_data_reg <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      phase_reg       <= phase_next;
      bit_reg         <= bit_next;
      ch_reg          <= ch_next;
      pending_reg     <= pending_next;
      sgl_reg         <= sgl_next;
      shift_reg       <= shift_next;
      sample_ch_reg   <= sample_ch_next;
      sample_data_reg <= sample_data_next;
    end
  end

  assign sample_ch   = sample_ch_reg;
  assign sample_data = sample_data_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bank
    logic [DATA_W-1:0] slice_reg;

    // Result bank slice, written when this channel's frame completes.
    always_ff @(posedge clk) begin
      if (!rst) slice_reg <= '0;
      else if (load && (ch_reg == 3'(gi))) slice_reg <= shift_reg;
    end

    assign results[gi*DATA_W +: DATA_W] = slice_reg;

`ifdef LSA_ADC_THRESH_EN
    logic line_reg;

    // Line detection bit, refreshed together with the result slice.
    always_ff @(posedge clk) begin
      if (!rst) line_reg <= 1'b0;
      else if (load && (ch_reg == 3'(gi))) line_reg <= (shift_reg >= thresh);
    end

    assign line_bits[gi] = line_reg;
`endif
  end

endmodule
